mul_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one pipelined Booth/CSA multiplier among NUM_REQ requesters.

---
 rtl/mul_rr_scheduler.sv | 110 +++++++++++
 tb/tb_mul_rr_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_scheduler.sv
// Round-robin front end for one shared pipelined multiplier: grants one requester
// per cycle, issues its operands, and steers each result back to its issuer.
module mul_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [2*DATA_WIDTH-1:0]       resp_res,
  output logic                          resp_ovf,
  output logic                          mul_en,
  output logic [DATA_WIDTH-1:0]         mul_op1,
  output logic [DATA_WIDTH-1:0]         mul_op2,
  input  logic [2*DATA_WIDTH-1:0]       mul_res,
  input  logic                          mul_ovf,
  output logic [15:0]                   issue_cnt
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: requester i holds req_valid[i] and its operands stable until a
  // cycle where req_valid[i] & req_ready[i]; that edge is the acceptance edge.
  // resp_valid has no ready: the owning requester must take the 1-cycle pulse.

  logic [ID_W-1:0] last_grant;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic [ID_W:0]   cand;

  logic            tag_v  [MUL_LATENCY];
  logic [ID_W-1:0] tag_id [MUL_LATENCY];

  // Search starts just after the previous winner and wraps around.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (ID_W+1)'(k + 1);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_valid && req_valid[cand[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = cand[ID_W-1:0];
      end
    end
    if (hold || !rst_n) begin
      grant_valid = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    mul_op1   = '0;
    mul_op2   = '0;
    if (grant_valid) begin
      req_ready[grant_id] = 1'b1;
      mul_op1 = req_op1[grant_id*DATA_WIDTH +: DATA_WIDTH];
      mul_op2 = req_op2[grant_id*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign mul_en = grant_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      issue_cnt  <= '0;
    end else if (grant_valid) begin
      last_grant <= grant_id;
      issue_cnt  <= issue_cnt + 16'd1;
    end
  end

  // Requester IDs ride alongside the multiplier pipeline so results can be steered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_v[s]  <= 1'b0;
        tag_id[s] <= '0;
      end
    end else begin
      tag_v[0]  <= grant_valid;
      tag_id[0] <= grant_id;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (rst_n && tag_v[MUL_LATENCY-1]) begin
      resp_valid[tag_id[MUL_LATENCY-1]] = 1'b1;
    end
  end

  assign resp_res = mul_res;
  assign resp_ovf = mul_ovf;

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler: requester/arbiter reference model drives stimulus,
// a behavioural multiplier closes the loop, and a monitor scoreboards responses.
module tb_mul_rr_scheduler;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int EW  = 1 + 2*DW + N;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            hold = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_op1 = '0;
  logic [N*DW-1:0] req_op2 = '0;
  logic [N-1:0]    resp_valid;
  logic [2*DW-1:0] resp_res;
  logic            resp_ovf;
  logic            mul_en;
  logic [DW-1:0]   mul_op1;
  logic [DW-1:0]   mul_op2;
  logic [2*DW-1:0] mul_res;
  logic            mul_ovf;
  logic [15:0]     issue_cnt;

  mul_rr_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2),
    .resp_valid(resp_valid), .resp_res(resp_res), .resp_ovf(resp_ovf),
    .mul_en(mul_en), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_res(mul_res), .mul_ovf(mul_ovf), .issue_cnt(issue_cnt)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural two-stage multiplier
  logic [2*DW-1:0] mp1 = '0, mp2 = '0;
  always @(posedge clk) begin
    mp1 <= {{DW{1'b0}}, mul_op1} * {{DW{1'b0}}, mul_op2};
    mp2 <= mp1;
  end
  assign mul_res = mp2;
  assign mul_ovf = (mp2[2*DW-1:DW] != '0);

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // scoreboard: {ovf, product, one-hot owner} with the cycle it must appear in
  logic [EW-1:0] exp_q[$];
  int            due_q[$];

  // reference model state
  logic          pend  [N];
  logic [DW-1:0] p_op1 [N];
  logic [DW-1:0] p_op2 [N];
  int            m_last = N - 1;
  logic [15:0]   m_cnt = '0;

  task automatic post(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (!pend[i]) begin
      pend[i]  = 1'b1;
      p_op1[i] = a;
      p_op2[i] = b;
    end
  endtask

  task automatic post_rand(input int i);
    post(i, DW'($urandom), DW'($urandom));
  endtask

  // Drive one cycle from a negedge, check issue side, advance to next negedge.
  task automatic step(input logic h, input logic r);
    int g;
    logic [N-1:0]    exp_rdy;
    logic [2*DW-1:0] prod;
    hold  = h;
    rst_n = r;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pend[i];
      req_op1[i*DW +: DW]  = p_op1[i];
      req_op2[i*DW +: DW]  = p_op2[i];
    end
    #1;
    g = -1;
    if (r && !h) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", 128'(req_ready), 128'(exp_rdy));
    check("mul_en", 128'(mul_en), 128'(g >= 0));
    check("issue_cnt", 128'(issue_cnt), 128'(m_cnt));
    if (g >= 0) begin
      check("mul_op1", 128'(mul_op1), 128'(p_op1[g]));
      check("mul_op2", 128'(mul_op2), 128'(p_op2[g]));
      prod = 64'(p_op1[g]) * 64'(p_op2[g]);
      exp_q.push_back({prod > 64'h0000_0000_FFFF_FFFF, prod, exp_rdy});
      due_q.push_back(cyc + LAT);
      pend[g] = 1'b0;
      m_last  = g;
      m_cnt   = m_cnt + 16'd1;
    end else begin
      check("mul_op1_idle", 128'(mul_op1), 128'(0));
    end
    if (!r) begin
      m_last = N - 1;
      m_cnt  = '0;
    end
    @(negedge clk);
  endtask

  // monitor: every cycle either the due response or silence
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        exp_q.delete();
        due_q.delete();
        check("resp_valid_rst", 128'(resp_valid), 128'(0));
      end else if (due_q.size() > 0 && due_q[0] == cyc) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        check("resp_valid", 128'(resp_valid), 128'(e[N-1:0]));
        check("resp_res", 128'(resp_res), 128'(e[N +: 2*DW]));
        check("resp_ovf", 128'(resp_ovf), 128'(e[EW-1]));
      end else begin
        check("resp_idle", 128'(resp_valid), 128'(0));
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      p_op1[i] = '0;
      p_op2[i] = '0;
    end
    @(negedge clk);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // single request after reset: 7*6
    post(0, 32'd7, 32'd6);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1);

    // all four continuously valid: strict rotation from requester 0
    step(1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) post(i, DW'(i + 1), 32'd10);
      step(1'b0, 1'b1);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (3) step(1'b0, 1'b1);

    // wrap past the top: grant 2, then 0 and 1 requesting
    post(2, 32'd11, 32'd12);
    step(1'b0, 1'b1);
    post(0, 32'd13, 32'd14);
    post(1, 32'd15, 32'd16);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // hold with an op in flight, then release
    post(3, 32'd100, 32'd3);
    step(1'b0, 1'b1);
    post(2, 32'd9, 32'd9);
    repeat (3) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1);

    // overflow boundary, then a small product
    post(0, 32'hFFFF_FFFF, 32'd2);
    step(1'b0, 1'b1);
    post(1, 32'd3, 32'd5);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1);

    // randomized traffic with occasional hold
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) post_rand(i);
      end
      step(($urandom_range(0, 7) == 0), 1'b1);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (3) step(1'b0, 1'b1);

    // reset one cycle after an issue discards the in-flight response
    post(1, 32'd21, 32'd2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);

    // issue counter wrap after 65536 grants
    for (int c = 0; c < 65536; c++) begin
      for (int i = 0; i < N; i++) post_rand(i);
      step(1'b0, 1'b1);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    #1;
    check("issue_cnt_wrap", 128'(issue_cnt), 128'(0));
    repeat (4) step(1'b0, 1'b1);

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
